// File: rtl/bram_pkg.sv
// Shared types and constants for the BRAM stream reader and its output FIFO.
package bram_pkg;

  localparam int BRAM_DEPTH  = 1024;
  localparam int BRAM_WIDTH  = 32;
  localparam int BRAM_ADDR_W = $clog2(BRAM_DEPTH);

  // Output buffer depth: one BRAM latency slot plus two words of slack keeps
  // the stream bubble-free while out_ready stays high.
  localparam int FIFO_DEPTH  = 3;
  localparam int FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef logic [BRAM_ADDR_W-1:0] addr_t;
  typedef logic [BRAM_WIDTH-1:0]  word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/stream_fifo.sv
// Small circular FIFO holding BRAM words until the downstream accepts them.
// Pointers and occupancy are reset; the storage array is data and is not.
module stream_fifo
  import bram_pkg::*;
#(
  parameter int DEPTH_FIFO = FIFO_DEPTH,
  parameter int WIDTH_BITS = BRAM_WIDTH
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              push,
  input  logic [WIDTH_BITS-1:0]             push_data,
  input  logic                              pop,
  output logic [$clog2(DEPTH_FIFO+1)-1:0]   count,
  output logic [WIDTH_BITS-1:0]             head
);

  localparam int CNT_W = $clog2(DEPTH_FIFO + 1);
  localparam int PTR_W = (DEPTH_FIFO > 1) ? $clog2(DEPTH_FIFO) : 1;

  logic [WIDTH_BITS-1:0] mem_q [DEPTH_FIFO];
  logic [PTR_W-1:0]      rd_q, rd_d;
  logic [PTR_W-1:0]      wr_q, wr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Depth need not be a power of two, so wrap by explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH_FIFO - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next pointers and occupancy from the push/pop strobes.
  always_comb begin
    rd_d  = pop  ? ptr_inc(rd_q) : rd_q;
    wr_d  = push ? ptr_inc(wr_q) : wr_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state: pointers and count, cleared by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Word storage written on push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= push_data;
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a wrapping BRAM address range, one read per cycle under a credit
// limit, and replays the words as a valid/ready stream with a last flag.
module bram_stream_reader
  import bram_pkg::*;
#(
  parameter int DEPTH      = BRAM_DEPTH,
  parameter int WIDTH_BITS = BRAM_WIDTH,
  parameter int NBITS_ADDR = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [NBITS_ADDR-1:0] start_addr,
  input  logic [NBITS_ADDR:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_read_en,
  output logic [NBITS_ADDR-1:0] bram_addr_read,
  input  logic [WIDTH_BITS-1:0] bram_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_BITS-1:0] out_data,
  output logic                  out_last
);

  localparam int                LEN_W   = NBITS_ADDR + 1;
  localparam int                OCC_W   = FIFO_CNT_W + 1;
  localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);

  state_e                  state_q, state_d;
  logic [NBITS_ADDR-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]        remaining_q, remaining_d;
  logic [LEN_W-1:0]        sent_q, sent_d;
  logic                    in_flight_q;
  logic                    done_q, done_d;

  logic                    read_en;
  logic                    credit_ok;
  logic [OCC_W-1:0]        occupancy;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic [WIDTH_BITS-1:0]   fifo_head;
  logic                    fifo_valid;
  logic                    fifo_pop;
  logic                    last_pop;

  // DEPTH may not be a power of two, so the address wraps by compare.
  function automatic logic [NBITS_ADDR-1:0] addr_inc(input logic [NBITS_ADDR-1:0] a);
    return (a == NBITS_ADDR'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign fifo_valid = (fifo_count != '0);
  assign fifo_pop   = fifo_valid & out_ready;
  assign last_pop   = fifo_pop & (sent_q == LEN_ONE);

  // Words buffered plus the one in the BRAM pipe must leave room for another.
  assign occupancy  = OCC_W'(fifo_count) + OCC_W'(in_flight_q);
  assign credit_ok  = (occupancy < OCC_W'(FIFO_DEPTH));

  // Next-state, read issue and completion decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    sent_d      = sent_q;
    done_d      = 1'b0;
    read_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d      = start_addr;
            remaining_d = length;
            sent_d      = length;
            state_d     = ST_READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if ((remaining_q != '0) && credit_ok) begin
          read_en     = 1'b1;
          addr_d      = addr_inc(addr_q);
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_ONE) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DRAIN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Output bookkeeping runs in READ and DRAIN alike.
    if ((state_q != ST_IDLE) && fifo_pop) begin
      sent_d = sent_q - 1'b1;
      if (last_pop) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // FSM, counters and the one-cycle BRAM latency tracker.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      sent_q      <= '0;
      in_flight_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      sent_q      <= sent_d;
      in_flight_q <= read_en;
      done_q      <= done_d;
    end
  end

  stream_fifo #(
    .DEPTH_FIFO (FIFO_DEPTH),
    .WIDTH_BITS (WIDTH_BITS)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (in_flight_q),
    .push_data (bram_data),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign bram_read_en   = read_en;
  assign bram_addr_read = busy ? addr_q : '0;
  assign out_valid      = fifo_valid;
  assign out_data       = fifo_valid ? fifo_head : '0;
  assign out_last       = fifo_valid & (sent_q == LEN_ONE);

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader paired with a 1-cycle BRAM model.
module tb_bram_stream_reader;

  localparam int DEPTH = 20;
  localparam int NA    = $clog2(DEPTH);
  localparam int W     = 32;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } exp_t;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [NA-1:0] start_addr;
  logic [NA:0]   length;
  logic          busy;
  logic          done;
  logic          bram_read_en;
  logic [NA-1:0] bram_addr_read;
  logic [W-1:0]  bram_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;

  logic [W-1:0]  ram [DEPTH];
  exp_t          exp_q[$];
  logic [NA-1:0] addr_exp_q[$];

  int checks;
  int errors;
  int exp_done;
  int done_cnt;
  int reads;
  int pops;
  int ready_mode;
  bit prev_stall;
  logic [W-1:0] prev_data;

  bram_stream_reader #(
    .DEPTH      (DEPTH),
    .WIDTH_BITS (W)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .start_addr     (start_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .bram_read_en   (bram_read_en),
    .bram_addr_read (bram_addr_read),
    .bram_data      (bram_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM model: registered read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bram_read_en) bram_data <= ram[bram_addr_read];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Downstream ready pattern: 0 always ready, 1 toggling, 2 random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expectations on every read strobe and every handshake.
  always @(negedge clk) begin
    if (!resetn) begin
      reads      = 0;
      pops       = 0;
      prev_stall = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        chk("busy_low_in_done", busy, 0);
      end
      if (prev_stall) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_data_held", out_data, prev_data);
      end
      if (bram_read_en) begin
        reads++;
        chk("reads_ahead_le3", (reads - pops) <= 3, 1);
        if (addr_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_read: got addr %0d expected no read", bram_addr_read);
        end else begin
          chk("read_addr", bram_addr_read, addr_exp_q.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        exp_t e;
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0d expected no word", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", out_last, e.last);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Issue one start pulse and enqueue the words the command must produce.
  task automatic issue(input int sa, input int len);
    start_addr = sa[NA-1:0];
    length     = len[NA:0];
    start      = 1'b1;
    for (int k = 0; k < len; k++) begin
      int   a;
      exp_t e;
      a      = (sa + k) % DEPTH;
      e.last = (k == len - 1);
      e.data = ram[a];
      exp_q.push_back(e);
      addr_exp_q.push_back(a[NA-1:0]);
    end
    exp_done++;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count cycles after the start edge until done; returns at done's negedge.
  task automatic wait_done(input int limit, output int done_k, output int first_v,
                           output bit any_rd);
    done_k  = -1;
    first_v = -1;
    any_rd  = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (out_valid && first_v < 0) first_v = k;
      if (bram_read_en) any_rd = 1'b1;
      if (done) begin
        done_k = k;
        break;
      end
    end
    if (done_k < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", limit);
    end
  endtask

  initial begin
    int dk, fv, dc0, sa, len;
    bit rd;
    checks     = 0;
    errors     = 0;
    exp_done   = 0;
    done_cnt   = 0;
    ready_mode = 0;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    resetn     = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = W'(i);

    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, bram_read_en, out_valid, out_last,
                          bram_addr_read, out_data}, 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Basic run, ready held high: exact latency and done cycle.
    issue(0, 8);
    wait_done(60, dk, fv, rd);
    chk("t1_first_valid_cycle", fv, 3);
    chk("t1_done_cycle", dk, 11);
    chk("t1_sb_empty", exp_q.size(), 0);

    // Range wrapping past DEPTH-1.
    issue(DEPTH - 2, 4);
    wait_done(60, dk, fv, rd);
    chk("t2_done_cycle", dk, 7);
    chk("t2_addr_q_empty", addr_exp_q.size(), 0);

    // Backpressure toggling every cycle.
    ready_mode = 1;
    issue(5, 16);
    wait_done(200, dk, fv, rd);
    chk("t3_sb_empty", exp_q.size(), 0);
    ready_mode = 0;

    // Zero-length command: done only, no reads or words.
    issue(3, 0);
    wait_done(10, dk, fv, rd);
    chk("t4_done_cycle", dk, 1);
    chk("t4_no_read", rd, 0);
    chk("t4_no_valid", fv, -1);

    // Full sweep under random backpressure.
    ready_mode = 2;
    issue(7, DEPTH);
    wait_done(20 * DEPTH + 40, dk, fv, rd);
    chk("t5_sb_empty", exp_q.size(), 0);
    ready_mode = 0;

    // Start pulsed while busy is ignored; start in the done cycle is taken.
    issue(2, 10);
    repeat (4) @(negedge clk);
    start_addr = NA'(11);
    length     = (NA + 1)'(3);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(80, dk, fv, rd);
    chk("t6_sb_empty", exp_q.size(), 0);
    issue(15, 6);
    wait_done(60, dk, fv, rd);
    chk("t6_b2b_done_cycle", dk, 9);

    // Random commands back to back under random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 6; i++) begin
      sa  = $urandom_range(0, DEPTH - 1);
      len = $urandom_range(1, DEPTH);
      issue(sa, len);
      wait_done(20 * len + 40, dk, fv, rd);
      chk("rand_sb_empty", exp_q.size(), 0);
    end
    ready_mode = 0;

    // Reset in the middle of a command aborts it without done.
    @(posedge clk);
    #1;
    issue(4, 10);
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    addr_exp_q.delete();
    exp_done--;
    #1;
    chk("async_reset_outputs", {busy, done, bram_read_en, out_valid, out_last,
                                bram_addr_read, out_data}, 0);
    dc0 = done_cnt;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_done_after_abort", done_cnt, dc0);
    @(posedge clk);
    #1;
    issue(9, 2);
    wait_done(40, dk, fv, rd);
    chk("post_reset_done_cycle", dk, 5);
    chk("post_reset_sb_empty", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    chk("done_count", done_cnt, exp_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side controller for a single-port-read on-chip buffer (the team's 1-cycle-latency BRAM). On a start command it walks a contiguous, wrapping address range, issues one read per cycle, absorbs the BRAM's fixed read latency, and presents the words as a valid/ready stream with a last flag. It sits between cache BRAMs and the compute datapath (weight/activation fetch).

## Interface
- DEPTH, default 1024: number of BRAM words; any value ≥ 2.
- WIDTH_BITS, default 32: word width.
- NBITS_ADDR, default $clog2(DEPTH): address width (derived; do not override).
- clk  in  1  single clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- start  in  1  command strobe; accepted only in IDLE.
- start_addr  in  NBITS_ADDR  first word address; must be < DEPTH.
- length  in  NBITS_ADDR+1  word count, 0..DEPTH.
- busy  out  1  high while a command is in progress.
- done  out  1  one-cycle pulse at command completion.
- bram_read_en  out  1  BRAM read strobe.
- bram_addr_read  out  NBITS_ADDR  BRAM read address.
- bram_data  in  WIDTH_BITS  BRAM read data, valid the cycle after bram_read_en is sampled.
- out_valid  out  1  stream word available.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH_BITS  stream word.
- out_last  out  1  qualifies final word of the command.

## Operation
- FSM: IDLE, READ, DRAIN. All outputs 0 in reset and in IDLE.
- IDLE: start=1 and length≠0 → latch start_addr, remaining=length, sent=length → READ. start with length=0 → done pulses next cycle, no reads, stays IDLE. start while busy ignored.
- READ: bram_read_en=1 when remaining>0 and (fifo_count + in_flight) < 3; each issue: address +1, wrapping DEPTH-1 → 0 (explicit compare, not power-of-2 truncation), remaining −1. remaining reaches 0 → DRAIN.
- in_flight: 1-bit register = bram_read_en of previous cycle; when set, bram_data is pushed into 3-entry FIFO that cycle.
- FIFO head drives out_data; out_valid = fifo not empty. Pop on out_valid & out_ready. Credit rule guarantees no overflow; out_ready has no combinational path to bram_read_en.
- out_last = out_valid and the head is word number length (sent counter == 1).
- DRAIN: on handshake of the last word → IDLE, done=1 for one cycle.
- busy = state ≠ IDLE; deasserts in the cycle done pulses.
- out_data holds stable while out_valid & !out_ready (AXI-style; valid never withdrawn).
- Reset asserted mid-command: immediate abort, FIFO emptied, all outputs 0, no done.

## Timing
- Start sampled at edge E0; bram_read_en high in cycle 1; data captured in FIFO at E2; first out_valid in cycle 3 (latency 3 cycles start→data).
- With out_ready held high: one word per cycle, no bubbles; length N completes last handshake in cycle N+2, done in cycle N+3.
- Backpressure: at most 3 words buffered; reads resume the cycle after a pop frees credit.
- A new start is accepted in the done cycle (state already IDLE).

## Structure
- Shared package bram_pkg: address/word typedefs parameterised via DEPTH/WIDTH_BITS constants, FSM state enum.
- One sub-module: stream_fifo (parameters DEPTH_FIFO=3, WIDTH_BITS; push, pop, count, head data; async active-low reset). Top holds FSM, counters, address wrap.
- Bench pairs the block with the team's bram model, driving bram_read_en/bram_addr_read into it.

## Test plan
- BRAM preloaded ram[i]=i; start_addr=0, length=8, out_ready=1 → out_data 0..7 in cycles 3..10, out_last with 7, done in cycle 11, exactly 8 read strobes.
- start_addr=DEPTH−2, length=4 → words DEPTH−2, DEPTH−1, 0, 1; bram_addr_read wraps to 0.
- length=16, out_ready toggling 1/0 each cycle → all 16 words in order, no loss/duplication, out_data stable while stalled, never >3 reads ahead of pops.
- length=0 → done pulse cycle 1, bram_read_en and out_valid never assert; length=DEPTH → full sweep, last word ram[start_addr−1].
- start pulsed again mid-command → ignored, stream unchanged; start in done cycle → second command follows back-to-back.
- resetn low in middle of length=10 command → outputs 0 asynchronously, no done; post-reset command of length 2 returns correct data.
